acia_tx_q: RTL and testbench
============================

// Module: acia_tx_q
// PURPOSE
//  Parametrised 6551-style async serial transmitter with transmit FIFO. Single BCLK domain,
//  BCLK = OVS x baud; host-side CDC lives upstream. Adds a programmable word length
//  (5..8 bits) and 1/1.5/2 stop bits. All character-format fields are latched at start bit.
// PARAMETERS
//  FIFO_DEPTH  4   FIFO entries; power of 2, >=2
//  OVS         16  BCLK cycles per bit; even, >=4
// PORTS
//  BCLK        in   1   oversample clock
//  RESET       in   1   asynchronous, active-low reset
//  WR_DATA     in   8   character; bits above word length ignored
//  WR_VALID    in   1   write request
//  WR_READY    out  1   FIFO not full; a write is accepted when WR_VALID & WR_READY
//  CTSB        in   1   clear-to-send, active-low
//  R_WLEN      in   2   00=8, 01=7, 10=6, 11=5 data bits
//  R_PME       in   1   parity enable
//  R_PMC       in   2   00 odd, 01 even, 10 mark, 11 space
//  R_SBN       in   1   extra stop bits (see BEHAVIOUR)
//  BRK         in   1   send break (ACIA_TX_BREAK_EN only)
//  TX          out  1   serial line, idle high
//  TXFULL      out  1   FIFO full (= ~WR_READY)
//  TX_EMPTY    out  1   FIFO empty and FSM in IDLE
//  FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1   occupied entries
// BEHAVIOUR
//  Reset values: TX=1, WR_READY=1, TXFULL=0, TX_EMPTY=1, FIFO_LEVEL=0, FSM=IDLE, counters=0.
//  Reset mid-character aborts the frame immediately; FIFO contents are discarded.
//  FIFO: write when full is dropped, with no level change. Write+pop on the same edge: level unchanged.
//  Write accepted on edge E1 -> entry visible at E2; IDLE pops it on E2 and drives TX=0.
//  States: IDLE, START, DATA, PARITY, STOP, BREAK.
//   IDLE: TX=1. If FIFO non-empty and CTSB=0: pop, latch data/WLEN/PME/PMC/SBN, go to START.
//     CTSB is sampled only in IDLE; deasserting CTSB mid-frame finishes the current character.
//   START: TX=0 for OVS cycles -> DATA.
//   DATA: LSB first, each bit for OVS cycles, WLEN bits total.
//     Running XOR covers only the transmitted bits.
//     After the last bit: go to PARITY if PME, else go to STOP.
//   PARITY: for OVS cycles. Odd = ~xor, even = xor, mark = 1, space = 0.
//   STOP: TX=1. Length is OVS cycles, except when SBN=1:
//     2*OVS cycles, or 1.5*OVS (OVS+OVS/2) if WLEN=5 and !PME, or 1*OVS if WLEN=8 and PME.
//     Then go to IDLE.
//  One mark cycle in IDLE separates back-to-back frames.
//  Frame length in BCLK cycles = OVS*(1+WLEN+PME)+stop. Example: 8N1, OVS=16 -> 160 cycles.
//  Bit counter is 3 bits; the oversample counter is $clog2(OVS) bits and wraps to 0 at each bit end.
// CONFIGURATION
//  `define ACIA_TX_BREAK_EN: in IDLE, BRK=1 has priority over the FIFO -> BREAK state.
//   BREAK: TX=0 while BRK is high. BRK is checked only in IDLE, so an in-flight frame completes.
//   On BRK deassert: TX=1 for OVS cycles of mandatory mark, then IDLE.
//  Without the macro: BRK port is present but ignored; BREAK state is absent.
// STRUCTURE
//  Package acia_pkg holds:
//   - state enum (3 bits)
//   - WLEN_8/7/6/5 and PMC_ODD/EVEN/MARK/SPACE codes
//   - a function returning the stop length in cycles from (WLEN, PME, SBN, OVS)
//  Sub-module acia_sync_fifo (DEPTH, WIDTH=8): wr/rd, full, empty, level. Reusable on the RX side.
// TESTING
//  1 8N1 OVS=16, write 0x55, CTSB=0 -> TX low 16 cycles, then 1,0,1,0,1,0,1,0, then 16 high;
//    TX_EMPTY=1 at cycle 161.
//  2 7E1, write 0x41 -> 7 data bits 1000001, then parity bit 0. With PMC=00 the parity bit is 1.
//  3 CTSB=1, write 6 bytes with FIFO_DEPTH=4 -> 4 accepted, WR_READY/TXFULL=1 from the 4th,
//    TX stays 1. Then CTSB=0 -> 4 frames, each separated by exactly 1 mark cycle.
//  4 5N, SBN=1, write 0x1F -> stop high for 24 cycles. With 8 bits, PME=1, SBN=1 -> stop 16 cycles.
//  5 RESET low in DATA bit 3 with 2 bytes queued -> TX=1 asynchronously, FIFO_LEVEL=0;
//    after release, no frame is sent.
//  6 (BREAK_EN) BRK=1 mid-frame -> frame completes, then TX=0 until BRK=0, then >=16 high
//    before the next start bit.

Source files
------------

// File: rtl/acia_pkg.sv
// acia_pkg: shared state, format codes and frame helpers for the ACIA TX path.
// Optional feature macro: ACIA_TX_BREAK_EN (break state in acia_tx_q).
package acia_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } tx_state_t;

   localparam logic [1:0] WLEN_8 = 2'b00;
   localparam logic [1:0] WLEN_7 = 2'b01;
   localparam logic [1:0] WLEN_6 = 2'b10;
   localparam logic [1:0] WLEN_5 = 2'b11;

   localparam logic [1:0] PMC_ODD   = 2'b00;
   localparam logic [1:0] PMC_EVEN  = 2'b01;
   localparam logic [1:0] PMC_MARK  = 2'b10;
   localparam logic [1:0] PMC_SPACE = 2'b11;

   typedef struct packed {
      logic [1:0] wlen;
      logic       pme;
      logic [1:0] pmc;
      logic       sbn;
   } tx_fmt_t;

   function automatic int unsigned stop_cycles(
      input logic [1:0]  wlen,
      input logic        pme,
      input logic        sbn,
      input int unsigned ovs
   );
      if (!sbn) return ovs;
      if (wlen == WLEN_5 && !pme) return ovs + ovs / 2;
      if (wlen == WLEN_8 && pme) return ovs;
      return ovs + ovs;
   endfunction

endpackage

// File: rtl/acia_sync_fifo.sv
// acia_sync_fifo: single-clock FIFO with level output, shared by TX and RX.
// Writes when full and reads when empty are ignored.
module acia_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     BCLK,
   input  logic                     RESET,
   input  logic                     wr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic             do_wr;
   logic             do_rd;

   assign full    = level == LW'(DEPTH);
   assign empty   = level == '0;
   assign do_wr   = wr & ~full;
   assign do_rd   = rd & ~empty;
   assign rd_data = mem[rp];

   always_ff @(posedge BCLK or negedge RESET) begin
      if (!RESET) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else begin
         if (do_wr) wp <= wp + AW'(1);
         if (do_rd) rp <= rp + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge BCLK) begin
      if (do_wr) mem[wp] <= wr_data;
   end

endmodule

// File: rtl/acia_tx_q.sv
// acia_tx_q: 6551-style serial transmitter with TX FIFO, 5..8 bits, 1/1.5/2 stop.
// Optional macro ACIA_TX_BREAK_EN adds the BRK-driven break state.
module acia_tx_q
   import acia_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int OVS        = 16
) (
   input  logic                          BCLK,
   input  logic                          RESET,
   input  logic [7:0]                    WR_DATA,
   input  logic                          WR_VALID,
   output logic                          WR_READY,
   input  logic                          CTSB,
   input  logic [1:0]                    R_WLEN,
   input  logic                          R_PME,
   input  logic [1:0]                    R_PMC,
   input  logic                          R_SBN,
   input  logic                          BRK,
   output logic                          TX,
   output logic                          TXFULL,
   output logic                          TX_EMPTY,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);
   localparam int OW = $clog2(OVS);

   tx_state_t   state;
   tx_fmt_t     fmt;
   logic [7:0]  shreg;
   logic [OW-1:0] ovs_cnt;
   logic [2:0]  bit_cnt;
   logic        par;
   logic        pop;
   logic        brk_req;
   logic        empty;
   logic        full;
   logic [7:0]  q_data;
   logic        ovs_end;
   logic        last_bit;
   logic        stop_end;
   logic        par_bit;
   logic [31:0] stop_len;
   logic [31:0] stop_pos;

`ifdef ACIA_TX_BREAK_EN
   logic brk_mark;
   assign brk_req = BRK;
`else
   logic unused_brk;
   assign unused_brk = BRK;
   assign brk_req    = 1'b0;
`endif

   acia_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .BCLK    (BCLK),
      .RESET   (RESET),
      .wr      (WR_VALID),
      .wr_data (WR_DATA),
      .rd      (pop),
      .rd_data (q_data),
      .full    (full),
      .empty   (empty),
      .level   (FIFO_LEVEL)
   );

   assign WR_READY = ~full;
   assign TXFULL   = full;
   assign TX_EMPTY = empty & (state == ST_IDLE);
   assign pop      = (state == ST_IDLE) & ~empty & ~CTSB & ~brk_req;

   assign ovs_end  = ovs_cnt == OW'(OVS - 1);
   assign last_bit = bit_cnt == (3'd7 - {1'b0, fmt.wlen});
   assign stop_len = stop_cycles(fmt.wlen, fmt.pme, fmt.sbn, OVS);
   // stop can exceed one bit time, so bit_cnt counts whole stop periods
   assign stop_pos = 32'(bit_cnt) * 32'(OVS) + 32'(ovs_cnt);
   assign stop_end = stop_pos == stop_len - 32'd1;

   always_comb begin
      par_bit = 1'b1;
      unique case (fmt.pmc)
         PMC_ODD:   par_bit = ~par;
         PMC_EVEN:  par_bit = par;
         PMC_MARK:  par_bit = 1'b1;
         PMC_SPACE: par_bit = 1'b0;
      endcase
   end

   always_ff @(posedge BCLK or negedge RESET) begin
      if (!RESET) begin
         state   <= ST_IDLE;
         TX      <= 1'b1;
         fmt     <= '0;
         shreg   <= '0;
         ovs_cnt <= '0;
         bit_cnt <= '0;
         par     <= 1'b0;
`ifdef ACIA_TX_BREAK_EN
         brk_mark <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               TX      <= 1'b1;
               ovs_cnt <= '0;
               bit_cnt <= '0;
`ifdef ACIA_TX_BREAK_EN
               if (brk_req) begin
                  state    <= ST_BREAK;
                  TX       <= 1'b0;
                  brk_mark <= 1'b0;
               end else
`endif
               if (pop) begin
                  state <= ST_START;
                  TX    <= 1'b0;
                  shreg <= q_data;
                  fmt   <= '{wlen: R_WLEN, pme: R_PME,
                             pmc: R_PMC, sbn: R_SBN};
               end
            end
            ST_START: begin
               ovs_cnt <= ovs_cnt + OW'(1);
               if (ovs_end) begin
                  ovs_cnt <= '0;
                  state   <= ST_DATA;
                  TX      <= shreg[0];
                  par     <= shreg[0];
               end
            end
            ST_DATA: begin
               ovs_cnt <= ovs_cnt + OW'(1);
               if (ovs_end) begin
                  ovs_cnt <= '0;
                  if (last_bit) begin
                     bit_cnt <= '0;
                     state   <= fmt.pme ? ST_PARITY : ST_STOP;
                     TX      <= fmt.pme ? par_bit : 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     shreg   <= shreg >> 1;
                     TX      <= shreg[1];
                     par     <= par ^ shreg[1];
                  end
               end
            end
            ST_PARITY: begin
               ovs_cnt <= ovs_cnt + OW'(1);
               if (ovs_end) begin
                  ovs_cnt <= '0;
                  state   <= ST_STOP;
                  TX      <= 1'b1;
               end
            end
            ST_STOP: begin
               TX <= 1'b1;
               if (stop_end) begin
                  state   <= ST_IDLE;
                  ovs_cnt <= '0;
                  bit_cnt <= '0;
               end else if (ovs_end) begin
                  ovs_cnt <= '0;
                  bit_cnt <= bit_cnt + 3'd1;
               end else begin
                  ovs_cnt <= ovs_cnt + OW'(1);
               end
            end
`ifdef ACIA_TX_BREAK_EN
            ST_BREAK: begin
               if (!brk_mark) begin
                  TX      <= 1'b0;
                  ovs_cnt <= '0;
                  if (!BRK) begin
                     brk_mark <= 1'b1;
                     TX       <= 1'b1;
                  end
               end else begin
                  ovs_cnt <= ovs_cnt + OW'(1);
                  if (ovs_end) begin
                     ovs_cnt  <= '0;
                     brk_mark <= 1'b0;
                     state    <= ST_IDLE;
                  end
               end
            end
`endif
            default: begin
               state <= ST_IDLE;
               TX    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acia_tx_q.sv
// tb_acia_tx_q: table vectors, FIFO/CTS/reset sequences and random frames
// checked against a per-cycle waveform model of each character.
module tb_acia_tx_q;
   localparam int OVS   = 16;
   localparam int DEPTH = 4;

   logic       BCLK = 1'b0;
   logic       RESET = 1'b1;
   logic [7:0] WR_DATA = 8'h00;
   logic       WR_VALID = 1'b0;
   logic       WR_READY;
   logic       CTSB = 1'b1;
   logic [1:0] R_WLEN = 2'b00;
   logic       R_PME = 1'b0;
   logic [1:0] R_PMC = 2'b00;
   logic       R_SBN = 1'b0;
   logic       BRK = 1'b0;
   logic       TX;
   logic       TXFULL;
   logic       TX_EMPTY;
   logic [2:0] FIFO_LEVEL;

   always #5 BCLK = ~BCLK;

   acia_tx_q #(.FIFO_DEPTH(DEPTH), .OVS(OVS)) dut (
      .BCLK(BCLK), .RESET(RESET), .WR_DATA(WR_DATA),
      .WR_VALID(WR_VALID), .WR_READY(WR_READY), .CTSB(CTSB),
      .R_WLEN(R_WLEN), .R_PME(R_PME), .R_PMC(R_PMC),
      .R_SBN(R_SBN), .BRK(BRK), .TX(TX), .TXFULL(TXFULL),
      .TX_EMPTY(TX_EMPTY), .FIFO_LEVEL(FIFO_LEVEL)
   );

   typedef struct {
      bit [7:0] d;
      bit [1:0] wlen;
      bit       pme;
      bit [1:0] pmc;
      bit       sbn;
      int       lat;
      bit       par;
   } vec_t;

   int total = 0;
   int bad   = 0;

   bit [7:0] sb[$];
   bit       exp_w[$];
   bit       act_w[$];
   int       gaps_q[$];
   bit [7:0] cur;
   bit       mon_en = 1'b0;
   bit       active = 1'b0;
   bit       ferr = 1'b0;
   bit       lo_skip = 1'b0;
   int       idx = 0;
   int       gap = 0;
   int       starts = 0;
   int       frames_done = 0;
`ifdef ACIA_TX_BREAK_EN
   bit       brk_mode = 1'b0;
   bit       brk_rel = 1'b0;
   int       hi_run = 0;
   int       last_hi = 0;
`endif

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int stop_of(int n, bit pme, bit sbn);
      if (!sbn) return OVS;
      if (n == 5 && !pme) return OVS + OVS / 2;
      if (n == 8 && pme) return OVS;
      return 2 * OVS;
   endfunction

   function automatic bit par_of(bit [7:0] d, int n, bit [1:0] pmc);
      int ones;
      ones = 0;
      for (int i = 0; i < n; i++) ones += int'(d[i]);
      case (pmc)
         2'd0:    return (ones % 2) == 0;
         2'd1:    return (ones % 2) == 1;
         2'd2:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic build(input bit [7:0] d);
      int n;
      n = 8 - int'(R_WLEN);
      exp_w.delete();
      repeat (OVS) exp_w.push_back(1'b0);
      for (int i = 0; i < n; i++)
         repeat (OVS) exp_w.push_back(d[i]);
      if (R_PME)
         repeat (OVS) exp_w.push_back(par_of(d, n, R_PMC));
      repeat (stop_of(n, R_PME, R_SBN)) exp_w.push_back(1'b1);
   endtask

   task automatic start_frame();
      starts++;
      gaps_q.push_back(gap);
      if (sb.size() == 0) begin
         chk("unexpected_start", 1, 0);
         lo_skip = 1'b1;
      end else begin
         cur = sb.pop_front();
         build(cur);
         act_w.delete();
         act_w.push_back(TX);
         ferr   = (TX !== exp_w[0]);
         idx    = 1;
         active = 1'b1;
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge BCLK);
         if (!mon_en) begin
            active  = 1'b0;
            lo_skip = 1'b0;
         end
`ifdef ACIA_TX_BREAK_EN
         else if (brk_mode) begin
            if (TX === 1'b1) hi_run++;
            else if (brk_rel && hi_run > 0) begin
               last_hi  = hi_run;
               brk_mode = 1'b0;
               gap      = hi_run;
               start_frame();
            end else hi_run = 0;
         end
`endif
         else if (active) begin
            act_w.push_back(TX);
            if (TX !== exp_w[idx]) ferr = 1'b1;
            idx++;
            if (idx == exp_w.size()) begin
               chk($sformatf("frame_%02h_err", cur), int'(ferr), 0);
               active = 1'b0;
               frames_done++;
               gap = 0;
            end
         end else if (TX !== 1'b1) begin
            if (!lo_skip) start_frame();
         end else begin
            gap++;
            lo_skip = 1'b0;
         end
      end
   endtask

   task automatic wr(input bit [7:0] d, output bit acc);
      @(posedge BCLK); #1;
      WR_DATA  = d;
      WR_VALID = 1'b1;
      acc = WR_READY;
      if (acc) sb.push_back(d);
      @(posedge BCLK); #1;
      WR_VALID = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      while (!(TX_EMPTY === 1'b1 && !active && sb.size() == 0)
             && n < budget) begin
         @(negedge BCLK);
         n++;
      end
      chk(name, int'(n < budget), 1);
   endtask

   task automatic set_fmt(input bit [1:0] w, input bit p,
                          input bit [1:0] m, input bit s);
      R_WLEN = w;
      R_PME  = p;
      R_PMC  = m;
      R_SBN  = s;
   endtask

   vec_t tbl[10];

   initial begin
      bit acc;
      int n;
      int acc_cnt;
      int f0;
      int s0;
      int lows;
      int pidx;

      tbl[0] = '{8'h55, 2'd0, 1'b0, 2'd0, 1'b0, 161, 1'b0};
      tbl[1] = '{8'h41, 2'd1, 1'b1, 2'd1, 1'b0, 161, 1'b0};
      tbl[2] = '{8'h41, 2'd1, 1'b1, 2'd0, 1'b0, 161, 1'b1};
      tbl[3] = '{8'h1F, 2'd3, 1'b0, 2'd0, 1'b1, 121, 1'b0};
      tbl[4] = '{8'hA5, 2'd0, 1'b1, 2'd1, 1'b1, 177, 1'b0};
      tbl[5] = '{8'h3C, 2'd2, 1'b1, 2'd2, 1'b1, 161, 1'b1};
      tbl[6] = '{8'hFF, 2'd3, 1'b1, 2'd3, 1'b0, 129, 1'b0};
      tbl[7] = '{8'h00, 2'd0, 1'b0, 2'd0, 1'b1, 177, 1'b0};
      tbl[8] = '{8'hEB, 2'd2, 1'b1, 2'd0, 1'b0, 145, 1'b1};
      tbl[9] = '{8'h9F, 2'd3, 1'b1, 2'd1, 1'b1, 145, 1'b1};

      fork
         monitor();
         begin
            #800000;
            $display("FAIL watchdog: simulation did not finish");
            $fatal(1, "watchdog");
         end
      join_none

      #1 RESET = 1'b0;
      #2;
      chk("rst_tx", int'(TX), 1);
      chk("rst_wr_ready", int'(WR_READY), 1);
      chk("rst_txfull", int'(TXFULL), 0);
      chk("rst_tx_empty", int'(TX_EMPTY), 1);
      chk("rst_level", int'(FIFO_LEVEL), 0);
      repeat (2) @(negedge BCLK);
      RESET  = 1'b1;
      mon_en = 1'b1;
      CTSB   = 1'b0;

      for (int v = 0; v < 10; v++) begin
         set_fmt(tbl[v].wlen, tbl[v].pme, tbl[v].pmc, tbl[v].sbn);
         wr(tbl[v].d, acc);
         n = 0;
         forever begin
            @(negedge BCLK);
            if (TX_EMPTY === 1'b1 || n > 400) break;
            n++;
         end
         chk($sformatf("vec%0d_latency", v), n, tbl[v].lat);
         if (tbl[v].pme) begin
            pidx = OVS * (9 - int'(tbl[v].wlen)) + OVS / 2;
            chk($sformatf("vec%0d_parity", v),
                int'(act_w[pidx]), int'(tbl[v].par));
         end
         wait_idle(100, $sformatf("vec%0d_idle", v));
      end

      set_fmt(2'd0, 1'b0, 2'd0, 1'b0);
      @(posedge BCLK); #1 CTSB = 1'b1;
      acc_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         wr(8'h30 + 8'(k), acc);
         acc_cnt += int'(acc);
         if (k == 3) begin
            chk("full_wr_ready", int'(WR_READY), 0);
            chk("full_txfull", int'(TXFULL), 1);
            chk("full_level", int'(FIFO_LEVEL), 4);
         end
      end
      chk("cts_accepted", acc_cnt, 4);
      lows = 0;
      repeat (40) begin
         @(negedge BCLK);
         if (TX !== 1'b1) lows++;
      end
      chk("cts_hold_tx_low", lows, 0);
      gaps_q.delete();
      f0 = frames_done;
      @(posedge BCLK); #1 CTSB = 1'b0;
      wait_idle(2000, "cts_idle");
      chk("cts_frames", frames_done - f0, 4);
      chk("cts_gap_count", gaps_q.size(), 4);
      for (int i = 1; i < 4; i++)
         chk($sformatf("cts_gap%0d", i), gaps_q[i], 1);

      wr(8'hC3, acc);
      wr(8'h5A, acc);
      wr(8'h81, acc);
      n = 0;
      while (!(active && idx >= OVS * 4 + 4) && n < 400) begin
         @(negedge BCLK);
         n++;
      end
      chk("rst_reach_bit3", int'(n < 400), 1);
      #3;
      RESET  = 1'b0;
      mon_en = 1'b0;
      sb.delete();
      #1;
      chk("midrst_tx", int'(TX), 1);
      chk("midrst_level", int'(FIFO_LEVEL), 0);
      chk("midrst_tx_empty", int'(TX_EMPTY), 1);
      repeat (3) @(posedge BCLK);
      #2 RESET = 1'b1;
      s0 = starts;
      mon_en = 1'b1;
      lows = 0;
      repeat (300) begin
         @(negedge BCLK);
         if (TX !== 1'b1) lows++;
      end
      chk("postrst_tx_low", lows, 0);
      chk("postrst_starts", starts - s0, 0);

      for (int b = 0; b < 5; b++) begin
         set_fmt(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         n = int'($urandom_range(3, 8));
         f0 = frames_done;
         acc_cnt = 0;
         for (int k = 0; k < n; k++) begin
            CTSB = ($urandom_range(0, 3) == 0);
            wr(8'($urandom_range(0, 255)), acc);
            acc_cnt += int'(acc);
            repeat ($urandom_range(0, 20)) @(posedge BCLK);
            #1;
         end
         CTSB = 1'b0;
         wait_idle(4000, $sformatf("rand%0d_idle", b));
         chk($sformatf("rand%0d_frames", b), frames_done - f0, acc_cnt);
      end

`ifdef ACIA_TX_BREAK_EN
      set_fmt(2'd0, 1'b0, 2'd0, 1'b0);
      wr(8'h96, acc);
      n = 0;
      while (!active && n < 100) begin
         @(negedge BCLK);
         n++;
      end
      @(posedge BCLK); #1 BRK = 1'b1;
      f0 = frames_done;
      n = 0;
      while (frames_done == f0 && n < 400) begin
         @(negedge BCLK);
         n++;
      end
      brk_mode = 1'b1;
      brk_rel  = 1'b0;
      hi_run   = 0;
      chk("brk_frame_done", frames_done - f0, 1);
      repeat (3) @(negedge BCLK);
      chk("brk_tx_low", int'(TX), 0);
      wr(8'h3A, acc);
      repeat (30) @(negedge BCLK);
      chk("brk_tx_held", int'(TX), 0);
      chk("brk_level", int'(FIFO_LEVEL), 1);
      @(posedge BCLK); #1 BRK = 1'b0;
      brk_rel = 1'b1;
      n = 0;
      while (brk_mode && n < 200) begin
         @(negedge BCLK);
         n++;
      end
      chk("brk_released", int'(brk_mode), 0);
      chk("brk_mark_ge_ovs", int'(last_hi >= OVS), 1);
      wait_idle(400, "brk_idle");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
